// File: rtl/dds_arb_pkg.sv
// Shared types and the round-robin picker for the DDS command arbiter.
// Lets several timed-command sources share one DDS update path.
package dds_arb_pkg;

  typedef enum logic [0:0] {IDLE, GAP} arb_state_t;

  localparam int DDS_CMD_WIDTH = 128;
  localparam int RR_MAX        = 8;

  // Returns {found, index}. Candidates are scanned starting one past last_grant and wrap modulo num_req.
  function automatic logic [3:0] rr_pick(input logic [7:0] nonempty,
                                         input logic [2:0] last_grant,
                                         input int         num_req);
    logic       found;
    logic [2:0] idx;
    int         cand;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 1; k <= RR_MAX; k++) begin
      if (k <= num_req && !found) begin
        cand = (int'(last_grant) + k) % num_req;
        if (nonempty[cand[2:0]]) begin
          found = 1'b1;
          idx   = cand[2:0];
        end
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/dds_arb_fifo.sv
// Single-clock per-source command FIFO.
// Flush takes priority over push, and a push onto a full FIFO succeeds only when that FIFO is popped in the same cycle.
module dds_arb_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic                  drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  do_push, do_pop;

  // The extra MSB on each pointer tells full from empty when the low bits match.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty && !flush;
    do_push  = push && !flush && (!full || do_pop);
    drop     = push && !flush && full && !do_pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/dds_cmd_arbiter.sv
// Round-robin arbiter that shares one DDS_Controller update path among NUM_REQ RTO sources.
// It can enforce an idle gap after each issued command.
module dds_cmd_arbiter
  import dds_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DDS_CMD_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_GAP    = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          busy,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(NUM_REQ)-1:0]    out_src,
  output logic [NUM_REQ-1:0]            fifo_full,
  output logic [NUM_REQ-1:0]            fifo_empty,
  output logic [NUM_REQ-1:0]            overflow_error,
  input  logic [NUM_REQ-1:0]            overflow_clear
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  arb_state_t            state_q, state_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [2:0]            last_grant_q, last_grant_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SRC_W-1:0]      out_src_q, out_src_d;
  logic [NUM_REQ-1:0]    overflow_q, overflow_d;

  logic [DATA_WIDTH-1:0] head [NUM_REQ];
  logic [NUM_REQ-1:0]    pop, drop;
  logic [3:0]            pick;
  logic [SRC_W-1:0]      grant_idx;
  logic                  grant;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
    dds_arb_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push      (req_valid[gi]),
      .push_data (req_data[gi*DATA_WIDTH +: DATA_WIDTH]),
      .pop       (pop[gi]),
      .head      (head[gi]),
      .full      (fifo_full[gi]),
      .empty     (fifo_empty[gi]),
      .drop      (drop[gi])
    );
  end

  always_comb begin
    pick      = rr_pick(8'(~fifo_empty), last_grant_q, NUM_REQ);
    grant_idx = pick[SRC_W-1:0];
    grant     = (state_q == IDLE) && !busy && !flush && pick[3];
    pop       = '0;
    if (grant) pop[grant_idx] = 1'b1;

    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    last_grant_d = last_grant_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          out_valid_d  = 1'b1;
          out_data_d   = head[grant_idx];
          out_src_d    = grant_idx;
          last_grant_d = pick[2:0];
          if (MIN_GAP > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_W'(MIN_GAP);
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q <= GAP_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fresh drop beats a same-cycle clear so no overflow is ever lost.
    overflow_d = (overflow_q & ~overflow_clear) | drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      gap_cnt_q    <= '0;
      last_grant_q <= 3'(NUM_REQ - 1);
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      overflow_q   <= '0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      overflow_q   <= overflow_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_src        = out_src_q;
  assign overflow_error = overflow_q;

endmodule

// File: tb/tb_dds_cmd_arbiter.sv
// Directed bench for dds_cmd_arbiter with two instances: MIN_GAP=0 (u_dut) and MIN_GAP=3 (u_gap).
// Both instances are driven by the same stimulus.
module tb_dds_cmd_arbiter;

  logic         clk = 1'b0;
  logic         reset, flush, busy;
  logic [3:0]   req_valid, overflow_clear;
  logic [511:0] req_data;

  logic         out_valid, g_out_valid;
  logic [127:0] out_data, g_out_data;
  logic [1:0]   out_src, g_out_src;
  logic [3:0]   fifo_full, fifo_empty, overflow_error;
  logic [3:0]   g_fifo_full, g_fifo_empty, g_overflow_error;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dds_cmd_arbiter #(.NUM_REQ(4), .DATA_WIDTH(128), .FIFO_DEPTH(4), .MIN_GAP(0)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_data(req_data),
    .busy(busy), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow_error(overflow_error),
    .overflow_clear(overflow_clear));

  dds_cmd_arbiter #(.NUM_REQ(4), .DATA_WIDTH(128), .FIFO_DEPTH(4), .MIN_GAP(3)) u_gap (
    .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_data(req_data),
    .busy(busy), .out_valid(g_out_valid), .out_data(g_out_data), .out_src(g_out_src),
    .fifo_full(g_fifo_full), .fifo_empty(g_fifo_empty), .overflow_error(g_overflow_error),
    .overflow_clear(overflow_clear));

  function automatic logic [127:0] word(input int src, input int n);
    return {8'(src), 8'(n), 112'h0123_4567_89AB_CDEF_0011_2233_4455};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; busy = 1'b0;
    req_valid = '0; req_data = '0; overflow_clear = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic push_one(input int src, input logic [127:0] w);
    req_valid = 4'(1 << src);
    req_data[src*128 +: 128] = w;
    tick();
    req_valid = '0;
  endtask

  task automatic test_reset();
    do_reset();
    if (fifo_empty !== 4'hF) begin $display("FAIL rst_empty: got %h want f", fifo_empty); fails++; end tests++;
    if (fifo_full !== 4'h0) begin $display("FAIL rst_full: got %h want 0", fifo_full); fails++; end tests++;
    if (out_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", out_valid); fails++; end tests++;
    if (out_data !== 128'h0) begin $display("FAIL rst_data: got %h want 0", out_data); fails++; end tests++;
    if (out_src !== 2'd0) begin $display("FAIL rst_src: got %0d want 0", out_src); fails++; end tests++;
    if (overflow_error !== 4'h0) begin $display("FAIL rst_ovf: got %h want 0", overflow_error); fails++; end tests++;
    // A grant that is about to be registered must be killed by reset.
    push_one(1, word(1, 9));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (out_valid !== 1'b0) begin $display("FAIL rst_abort_valid: got %b want 0", out_valid); fails++; end tests++;
    if (fifo_empty !== 4'hF) begin $display("FAIL rst_abort_empty: got %h want f", fifo_empty); fails++; end tests++;
  endtask

  task automatic test_single_push();
    do_reset();
    tick(); tick(); tick();
    push_one(0, word(0, 1));
    if (fifo_empty !== 4'hE) begin $display("FAIL single_written: got %h want e", fifo_empty); fails++; end tests++;
    if (out_valid !== 1'b0) begin $display("FAIL single_nobypass: got %b want 0", out_valid); fails++; end tests++;
    tick();
    if (out_valid !== 1'b1) begin $display("FAIL single_valid: got %b want 1", out_valid); fails++; end tests++;
    if (out_data !== word(0, 1)) begin $display("FAIL single_data: got %h want %h", out_data, word(0, 1)); fails++; end tests++;
    if (out_src !== 2'd0) begin $display("FAIL single_src: got %0d want 0", out_src); fails++; end tests++;
    if (fifo_empty !== 4'hF) begin $display("FAIL single_empty: got %h want f", fifo_empty); fails++; end tests++;
    tick();
    if (out_valid !== 1'b0) begin $display("FAIL single_pulse: got %b want 0", out_valid); fails++; end tests++;
    if (out_data !== word(0, 1)) begin $display("FAIL single_hold: got %h want %h", out_data, word(0, 1)); fails++; end tests++;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int burst = 0; burst < 2; burst++) begin
      req_valid = 4'hF;
      for (int s = 0; s < 4; s++) req_data[s*128 +: 128] = word(s, 16 + burst);
      tick();
      req_valid = '0;
      for (int k = 0; k < 4; k++) begin
        tick();
        if (out_valid !== 1'b1) begin $display("FAIL rr_valid b%0d k%0d: got %b want 1", burst, k, out_valid); fails++; end tests++;
        if (out_src !== 2'(k)) begin $display("FAIL rr_src b%0d k%0d: got %0d want %0d", burst, k, out_src, k); fails++; end tests++;
        if (out_data !== word(k, 16 + burst)) begin $display("FAIL rr_data b%0d k%0d: got %h want %h", burst, k, out_data, word(k, 16 + burst)); fails++; end tests++;
      end
      tick();
      if (out_valid !== 1'b0) begin $display("FAIL rr_idle b%0d: got %b want 0", burst, out_valid); fails++; end tests++;
    end
    // After last grant 3: sources 3 and 1 pending, 1 must go first.
    req_valid = 4'b1010;
    req_data[1*128 +: 128] = word(1, 30);
    req_data[3*128 +: 128] = word(3, 30);
    tick();
    req_valid = '0;
    tick();
    if (out_src !== 2'd1) begin $display("FAIL rr_sparse_first: got %0d want 1", out_src); fails++; end tests++;
    tick();
    if (out_src !== 2'd3) begin $display("FAIL rr_sparse_second: got %0d want 3", out_src); fails++; end tests++;
  endtask

  task automatic test_min_gap();
    do_reset();
    push_one(1, word(1, 40));
    push_one(1, word(1, 41));
    if (g_out_valid !== 1'b1) begin $display("FAIL gap_first_valid: got %b want 1", g_out_valid); fails++; end tests++;
    if (g_out_data !== word(1, 40)) begin $display("FAIL gap_first_data: got %h want %h", g_out_data, word(1, 40)); fails++; end tests++;
    if (out_valid !== 1'b1) begin $display("FAIL nogap_first: got %b want 1", out_valid); fails++; end tests++;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (g_out_valid !== 1'b0) begin $display("FAIL gap_quiet k%0d: got %b want 0", k, g_out_valid); fails++; end tests++;
      if (k == 0 && out_data !== word(1, 41)) begin $display("FAIL nogap_b2b: got %h want %h", out_data, word(1, 41)); fails++; end
      if (k == 0) tests++;
    end
    tick();
    if (g_out_valid !== 1'b1) begin $display("FAIL gap_second_valid: got %b want 1", g_out_valid); fails++; end tests++;
    if (g_out_data !== word(1, 41)) begin $display("FAIL gap_second_data: got %h want %h", g_out_data, word(1, 41)); fails++; end tests++;
  endtask

  task automatic test_overflow();
    do_reset();
    busy = 1'b1;
    for (int n = 0; n < 4; n++) push_one(2, word(2, 50 + n));
    if (fifo_full[2] !== 1'b1) begin $display("FAIL ovf_full: got %b want 1", fifo_full[2]); fails++; end tests++;
    if (overflow_error !== 4'h0) begin $display("FAIL ovf_none_yet: got %h want 0", overflow_error); fails++; end tests++;
    push_one(2, word(2, 54));
    if (overflow_error !== 4'b0100) begin $display("FAIL ovf_set: got %h want 4", overflow_error); fails++; end tests++;
    if (out_valid !== 1'b0) begin $display("FAIL ovf_busy_hold: got %b want 0", out_valid); fails++; end tests++;
    busy = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== word(2, 50 + n)) begin
        $display("FAIL ovf_drain n%0d: got v=%b %h want v=1 %h", n, out_valid, out_data, word(2, 50 + n)); fails++;
      end tests++;
    end
    tick();
    if (out_valid !== 1'b0) begin $display("FAIL ovf_dropped_word: got %b want 0", out_valid); fails++; end tests++;
    if (overflow_error !== 4'b0100) begin $display("FAIL ovf_sticky: got %h want 4", overflow_error); fails++; end tests++;
    // New overflow in the same cycle as its clear keeps the flag set.
    busy = 1'b1;
    for (int n = 0; n < 4; n++) push_one(2, word(2, 60 + n));
    overflow_clear = 4'b0100;
    push_one(2, word(2, 64));
    overflow_clear = '0;
    if (overflow_error !== 4'b0100) begin $display("FAIL ovf_clear_race: got %h want 4", overflow_error); fails++; end tests++;
    overflow_clear = 4'b0100;
    tick();
    overflow_clear = '0;
    if (overflow_error !== 4'h0) begin $display("FAIL ovf_clear: got %h want 0", overflow_error); fails++; end tests++;
    busy = 1'b0;
  endtask

  task automatic test_push_pop_full();
    do_reset();
    busy = 1'b1;
    for (int n = 0; n < 4; n++) push_one(3, word(3, 70 + n));
    busy = 1'b0;
    push_one(3, word(3, 74));
    busy = 1'b1;
    if (out_valid !== 1'b1 || out_data !== word(3, 70)) begin $display("FAIL pp_grant: got v=%b %h want v=1 %h", out_valid, out_data, word(3, 70)); fails++; end tests++;
    if (overflow_error !== 4'h0) begin $display("FAIL pp_no_ovf: got %h want 0", overflow_error); fails++; end tests++;
    if (fifo_full[3] !== 1'b1) begin $display("FAIL pp_still_full: got %b want 1", fifo_full[3]); fails++; end tests++;
    busy = 1'b0;
    for (int n = 1; n < 5; n++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== word(3, 70 + n)) begin
        $display("FAIL pp_drain n%0d: got v=%b %h want v=1 %h", n, out_valid, out_data, word(3, 70 + n)); fails++;
      end tests++;
    end
    if (fifo_empty !== 4'hF) begin $display("FAIL pp_empty: got %h want f", fifo_empty); fails++; end tests++;
  endtask

  task automatic test_flush();
    do_reset();
    busy = 1'b1;
    for (int n = 0; n < 5; n++) push_one(2, word(2, 80 + n));
    busy = 1'b0;
    tick();
    flush = 1'b1;
    req_valid = 4'b0010;
    req_data[1*128 +: 128] = word(1, 90);
    #1;
    if (out_valid !== 1'b1 || out_data !== word(2, 80)) begin $display("FAIL flush_keeps_pulse: got v=%b %h want v=1 %h", out_valid, out_data, word(2, 80)); fails++; end tests++;
    tick();
    flush = 1'b0;
    req_valid = '0;
    if (fifo_empty !== 4'hF) begin $display("FAIL flush_empty: got %h want f", fifo_empty); fails++; end tests++;
    if (out_valid !== 1'b0) begin $display("FAIL flush_no_grant: got %b want 0", out_valid); fails++; end tests++;
    if (overflow_error !== 4'b0100) begin $display("FAIL flush_ovf_kept: got %h want 4", overflow_error); fails++; end tests++;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (out_valid !== 1'b0) begin $display("FAIL flush_quiet k%0d: got %b want 0", k, out_valid); fails++; end tests++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_push();
    test_round_robin();
    test_min_gap();
    test_overflow();
    test_push_pop_full();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
